// File: rtl/ip_pkg.sv
// ip_pkg: shared FP32 types, accumulator FSM states and a leading-zero counter
package ip_pkg;

    typedef logic [31:0] fp32_t;

    localparam fp32_t FP32_ZERO = 32'h0000_0000;
    localparam fp32_t FP32_QNAN = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        BIAS,
        OUT
    } ip_acc_state_e;

    // Leading zeros of a 27-bit aligned mantissa; 27 when the value is zero
    function automatic logic [4:0] lzc27(input logic [26:0] v);
        logic [4:0] n;
        n = 5'd27;
        for (int i = 0; i < 27; i++) begin
            if (v[i]) n = 5'(26 - i);
        end
        return n;
    endfunction

endpackage

// File: rtl/ip_accumulate_float_add.sv
// float_add: pipelined FP32 adder (round-to-nearest-even), result LAT edges after operands, aclr clears the pipe
module float_add
    import ip_pkg::*;
#(
    parameter int LAT = 7
) (
    input  logic  clk,
    input  logic  aclr,
    input  fp32_t a,
    input  fp32_t b,
    output fp32_t result
);

    logic        swap;
    fp32_t       x;
    fp32_t       y;
    logic [7:0]  ex;
    logic [7:0]  ey;
    logic [7:0]  diff;
    logic [4:0]  dsh;
    logic [4:0]  lz;
    logic [23:0] mx;
    logic [23:0] my;
    logic [55:0] wide;
    logic [27:0] fx;
    logic [27:0] fy;
    logic [27:0] s;
    logic [26:0] s2;
    logic [9:0]  sh;
    logic [9:0]  e;
    logic [9:0]  ef;
    logic        up;
    logic [30:0] mag;
    fp32_t       fin;
    fp32_t       sum_d;
    fp32_t       pipe_q [LAT];

    logic nan_a, nan_b, inf_a, inf_b;

    assign nan_a = (&a[30:23]) & (|a[22:0]);
    assign nan_b = (&b[30:23]) & (|b[22:0]);
    assign inf_a = (&a[30:23]) & ~(|a[22:0]);
    assign inf_b = (&b[30:23]) & ~(|b[22:0]);

    // Align the smaller magnitude, add/subtract with guard/round/sticky, normalise, round, then apply NaN/Inf rules
    always_comb begin
        swap = b[30:0] > a[30:0];
        x    = swap ? b : a;
        y    = swap ? a : b;
        ex   = (x[30:23] == 8'd0) ? 8'd1 : x[30:23];
        ey   = (y[30:23] == 8'd0) ? 8'd1 : y[30:23];
        mx   = {|x[30:23], x[22:0]};
        my   = {|y[30:23], y[22:0]};
        diff = ex - ey;
        dsh  = (diff > 8'd31) ? 5'd31 : diff[4:0];
        wide = {1'b0, my, 3'b000, 28'd0} >> dsh;
        fx   = {1'b0, mx, 3'b000};
        fy   = wide[55:28] | {27'd0, |wide[27:0]};
        s    = (x[31] == y[31]) ? fx + fy : fx - fy;
        lz   = lzc27(s[26:0]);
        sh   = ({5'd0, lz} < ({2'd0, ex} - 10'd1)) ? {5'd0, lz} : ({2'd0, ex} - 10'd1);
        s2   = s[27] ? {s[27:2], |s[1:0]} : (s[26:0] << sh);
        e    = s[27] ? ({2'd0, ex} + 10'd1) : ({2'd0, ex} - sh);
        ef   = s2[26] ? e : 10'd0;
        up   = s2[2] & (s2[3] | s2[1] | s2[0]);
        mag  = (ef >= 10'd255) ? {8'hFF, 23'd0} : ({ef[7:0], s2[25:3]} + {30'd0, up});
        fin  = (s == 28'd0) ? {x[31] & y[31], 31'd0} : {x[31], mag};
        sum_d = (nan_a | nan_b | (inf_a & inf_b & (a[31] != b[31]))) ? FP32_QNAN :
                inf_a ? a : inf_b ? b : fin;
    end

    // Delay line giving the fixed LAT-edge latency; cleared asynchronously to drop in-flight sums
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            for (int i = 0; i < LAT; i++) pipe_q[i] <= FP32_ZERO;
        end else begin
            pipe_q[0] <= sum_d;
            for (int i = 1; i < LAT; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign result = pipe_q[LAT-1];

endmodule

// File: rtl/ip_accumulate.sv
// ip_accumulate: folds FP32 partial dot-product chunks of one neuron, adds bias, emits result under valid/ready
// Optional IP_ACC_RELU_EN: results with the sign bit set are replaced by +0.0
module ip_accumulate
    import ip_pkg::*;
#(
    parameter int ADD_LAT = 7,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      in_data,
    input  logic [7:0]       in_id,
    input  logic             in_last,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      bias,
    output logic [31:0]      out_data,
    output logic [7:0]       out_id,
    output logic [CNT_W-1:0] out_count,
    output logic             out_err,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int LAT_W = (ADD_LAT < 2) ? 1 : $clog2(ADD_LAT + 1);

    ip_acc_state_e    state_q, state_d;
    fp32_t            acc_q, acc_d;
    fp32_t            op_a_q, op_a_d;
    fp32_t            op_b_q, op_b_d;
    fp32_t            bias_q, bias_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [LAT_W-1:0] lat_q, lat_d;
    logic [7:0]       id_q, id_d;
    logic             last_q, last_d;
    logic             err_q, err_d;
    logic             in_ready_q, in_ready_d;
    fp32_t            out_data_q, out_data_d;
    logic [7:0]       out_id_q, out_id_d;
    logic [CNT_W-1:0] out_count_q, out_count_d;
    logic             out_err_q, out_err_d;
    logic             out_valid_q, out_valid_d;

    fp32_t sum;
    fp32_t res;
    logic  accept;
    logic  lat_done;

    float_add #(.LAT(ADD_LAT)) u_add (
        .clk    (clk),
        .aclr   (!reset),
        .a      (op_a_q),
        .b      (op_b_q),
        .result (sum)
    );

`ifdef IP_ACC_RELU_EN
    assign res = sum[31] ? FP32_ZERO : sum;
`else
    assign res = sum;
`endif

    assign accept   = in_valid & in_ready_q & (state_q == IDLE);
    assign lat_done = (lat_q == LAT_W'(ADD_LAT));

    // Next-state and datapath: the single adder is shared, chunk folds in ADD then bias in BIAS
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        bias_d      = bias_q;
        cnt_d       = cnt_q;
        lat_d       = lat_q;
        id_d        = id_q;
        last_d      = last_q;
        err_d       = err_q;
        out_data_d  = out_data_q;
        out_id_d    = out_id_q;
        out_count_d = out_count_q;
        out_err_d   = out_err_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: if (accept) begin
                op_a_d  = acc_q;
                op_b_d  = in_data;
                cnt_d   = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
                lat_d   = '0;
                id_d    = (cnt_q == '0) ? in_id : id_q;
                err_d   = err_q | ((cnt_q != '0) & (in_id != id_q));
                bias_d  = in_last ? bias : bias_q;
                last_d  = in_last;
                state_d = ADD;
            end
            ADD: if (lat_done) begin
                acc_d   = sum;
                lat_d   = '0;
                op_a_d  = last_q ? sum : op_a_q;
                op_b_d  = last_q ? bias_q : op_b_q;
                state_d = last_q ? BIAS : IDLE;
            end else begin
                lat_d = lat_q + LAT_W'(1);
            end
            BIAS: if (lat_done) begin
                out_data_d  = res;
                out_id_d    = id_q;
                out_count_d = cnt_q;
                out_err_d   = err_q;
                out_valid_d = 1'b1;
                state_d     = OUT;
            end else begin
                lat_d = lat_q + LAT_W'(1);
            end
            OUT: if (out_ready) begin
                out_valid_d = 1'b0;
                acc_d       = FP32_ZERO;
                cnt_d       = '0;
                err_d       = 1'b0;
                last_d      = 1'b0;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
        in_ready_d = (state_d == IDLE);
    end

    // State and registered outputs; in_ready rises one edge after reset release
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            acc_q       <= FP32_ZERO;
            op_a_q      <= FP32_ZERO;
            op_b_q      <= FP32_ZERO;
            bias_q      <= FP32_ZERO;
            cnt_q       <= '0;
            lat_q       <= '0;
            id_q        <= '0;
            last_q      <= 1'b0;
            err_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            out_data_q  <= FP32_ZERO;
            out_id_q    <= '0;
            out_count_q <= '0;
            out_err_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            bias_q      <= bias_d;
            cnt_q       <= cnt_d;
            lat_q       <= lat_d;
            id_q        <= id_d;
            last_q      <= last_d;
            err_q       <= err_d;
            in_ready_q  <= in_ready_d;
            out_data_q  <= out_data_d;
            out_id_q    <= out_id_d;
            out_count_q <= out_count_d;
            out_err_q   <= out_err_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_data  = out_data_q;
    assign out_id    = out_id_q;
    assign out_count = out_count_q;
    assign out_err   = out_err_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_ip_accumulate.sv
// tb_ip_accumulate: directed scenarios for ip_accumulate with ADD_LAT=7, CNT_W=8
module tb_ip_accumulate;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] in_data = '0;
    logic [7:0]  in_id = '0;
    logic        in_last = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] bias = '0;
    logic [31:0] out_data;
    logic [7:0]  out_id;
    logic [7:0]  out_count;
    logic        out_err;
    logic        out_valid;
    logic        out_ready = 1'b0;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    ip_accumulate #(.ADD_LAT(7), .CNT_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_id     (in_id),
        .in_last   (in_last),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bias      (bias),
        .out_data  (out_data),
        .out_id    (out_id),
        .out_count (out_count),
        .out_err   (out_err),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Offer one chunk once in_ready is seen; returns the edge count right after the accept edge
    task automatic send(input logic [31:0] d, input logic [7:0] id, input logic last,
                        input logic [31:0] b, output int acc_cyc);
        int n;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL send_timeout in_ready=%b required 1", in_ready);
        end
        in_data  = d;
        in_id    = id;
        in_last  = last;
        bias     = b;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        acc_cyc  = cyc;
    endtask

    task automatic wait_out(output int vcyc);
        int n;
        n = 0;
        while (!out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (out_valid !== 1'b1) begin
            failures++;
            $display("FAIL out_timeout out_valid=%b required 1", out_valid);
        end
        vcyc = cyc;
    endtask

    task automatic handshake;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({in_ready, out_valid, out_data, out_id, out_count, out_err} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got rdy=%b vld=%b data=%h id=%h cnt=%h err=%b required all 0",
                     in_ready, out_valid, out_data, out_id, out_count, out_err);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_ready got %b required 1", in_ready);
        end
    endtask

    task automatic test_single_chunk;
        int c0, v;
        send(32'h3F80_0000, 8'h12, 1'b1, 32'h3F00_0000, c0);
        wait_out(v);
        checks++;
        if (v - c0 !== 16) begin failures++; $display("FAIL t1_latency got %0d required 16", v - c0); end
        checks++;
        if (out_data !== 32'h3FC0_0000) begin failures++; $display("FAIL t1_data got %h required 3fc00000", out_data); end
        checks++;
        if ({out_id, out_count, out_err} !== {8'h12, 8'd1, 1'b0}) begin
            failures++;
            $display("FAIL t1_meta got id=%h cnt=%0d err=%b required id=12 cnt=1 err=0", out_id, out_count, out_err);
        end
        handshake();
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL t1_valid_drop got %b required 0", out_valid); end
    endtask

    task automatic test_multi_chunk;
        int c0, c1, c2, v;
        send(32'h3F80_0000, 8'h01, 1'b0, 32'h0, c0);
        checks++;
        if (in_ready !== 1'b0) begin failures++; $display("FAIL t2_ready_low got %b required 0", in_ready); end
        send(32'h4000_0000, 8'h01, 1'b0, 32'h0, c1);
        checks++;
        if (c1 - c0 !== 9) begin failures++; $display("FAIL t2_period1 got %0d required 9", c1 - c0); end
        send(32'h4040_0000, 8'h01, 1'b1, 32'hBF80_0000, c2);
        checks++;
        if (c2 - c1 !== 9) begin failures++; $display("FAIL t2_period2 got %0d required 9", c2 - c1); end
        wait_out(v);
        checks++;
        if (out_data !== 32'h40A0_0000) begin failures++; $display("FAIL t2_data got %h required 40a00000", out_data); end
        checks++;
        if (out_count !== 8'd3) begin failures++; $display("FAIL t2_count got %0d required 3", out_count); end
        handshake();
    endtask

    task automatic test_backpressure;
        int c0, v;
        logic ok;
        send(32'h4000_0000, 8'h20, 1'b1, 32'h3F80_0000, c0);
        wait_out(v);
        ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if ({out_valid, in_ready, out_data, out_id, out_count, out_err} !== {1'b1, 1'b0, 32'h4040_0000, 8'h20, 8'd1, 1'b0})
                ok = 1'b0;
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL t3_hold got vld=%b rdy=%b data=%h id=%h required vld=1 rdy=0 data=40400000 id=20",
                     out_valid, in_ready, out_data, out_id);
        end
        out_ready = 1'b1;
        checks++;
        if (in_ready !== 1'b0) begin failures++; $display("FAIL t3_ready_in_hs got %b required 0", in_ready); end
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            failures++;
            $display("FAIL t3_after_hs got vld=%b rdy=%b required vld=0 rdy=1", out_valid, in_ready);
        end
        send(32'h3F80_0000, 8'h21, 1'b1, 32'h0, c0);
        wait_out(v);
        checks++;
        if ({out_data, out_count} !== {32'h3F80_0000, 8'd1}) begin
            failures++;
            $display("FAIL t3_fresh got data=%h cnt=%0d required 3f800000 cnt=1", out_data, out_count);
        end
        handshake();
    endtask

    task automatic test_id_mismatch;
        int c, v;
        send(32'h3F80_0000, 8'h05, 1'b0, 32'h0, c);
        send(32'h3F80_0000, 8'h06, 1'b1, 32'h0, c);
        wait_out(v);
        checks++;
        if ({out_data, out_id, out_count, out_err} !== {32'h4000_0000, 8'h05, 8'd2, 1'b1}) begin
            failures++;
            $display("FAIL t4_err got data=%h id=%h cnt=%0d err=%b required 40000000 05 2 1",
                     out_data, out_id, out_count, out_err);
        end
        handshake();
        send(32'h3F80_0000, 8'h07, 1'b0, 32'h0, c);
        send(32'h3F80_0000, 8'h07, 1'b1, 32'h0, c);
        wait_out(v);
        checks++;
        if ({out_id, out_err} !== {8'h07, 1'b0}) begin
            failures++;
            $display("FAIL t4_clean got id=%h err=%b required 07 0", out_id, out_err);
        end
        handshake();
    endtask

    task automatic test_mid_reset;
        int c, v, seen;
        send(32'h4000_0000, 8'h30, 1'b0, 32'h0, c);
        send(32'h4080_0000, 8'h30, 1'b1, 32'h3F80_0000, c);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if ({in_ready, out_valid, out_data, out_id, out_count, out_err} !== '0) begin
            failures++;
            $display("FAIL t5_reset_outputs got rdy=%b vld=%b data=%h required all 0", in_ready, out_valid, out_data);
        end
        @(negedge clk);
        reset = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        checks++;
        if (seen !== 0) begin failures++; $display("FAIL t5_no_partial got %0d valid cycles required 0", seen); end
        send(32'h3F80_0000, 8'h31, 1'b1, 32'h0, c);
        wait_out(v);
        checks++;
        if ({out_data, out_id, out_count, out_err} !== {32'h3F80_0000, 8'h31, 8'd1, 1'b0}) begin
            failures++;
            $display("FAIL t5_after got data=%h id=%h cnt=%0d err=%b required 3f800000 31 1 0",
                     out_data, out_id, out_count, out_err);
        end
        handshake();
    endtask

    task automatic test_negative;
        int c, v;
        logic [31:0] exp_d;
`ifdef IP_ACC_RELU_EN
        exp_d = 32'h0000_0000;
`else
        exp_d = 32'hC000_0000;
`endif
        send(32'hC040_0000, 8'h40, 1'b1, 32'h3F80_0000, c);
        wait_out(v);
        checks++;
        if (out_data !== exp_d) begin failures++; $display("FAIL t6_negative got %h required %h", out_data, exp_d); end
        handshake();
    endtask

    task automatic test_saturate;
        int c, v;
        for (int i = 0; i < 257; i++) send(32'h0, 8'h50, (i == 256), 32'h0, c);
        wait_out(v);
        checks++;
        if ({out_data, out_count, out_err} !== {32'h0, 8'hFF, 1'b0}) begin
            failures++;
            $display("FAIL sat_count got data=%h cnt=%0d err=%b required 00000000 255 0", out_data, out_count, out_err);
        end
        handshake();
    endtask

    initial begin
        test_reset();
        test_single_chunk();
        test_multi_chunk();
        test_backpressure();
        test_id_mismatch();
        test_mid_reset();
        test_negative();
        test_saturate();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

endmodule
